fft_sdf_stage: RTL

- Streaming radix-2 decimation-in-frequency (DIF) FFT stage, single-path delay-feedback (SDF) architecture.
- Accepts one complex sample per clock and emits one complex sample per clock.
- Successor to the fully parallel combinational stage: parametrised data and twiddle width, optional 1/2 scaling, valid/start-of-frame handling, and an internal delay buffer.
- log2(N) instances chained with STAGE = 0..log2(N)-1 form a pipelined FFT.

---
 rtl/fft_pkg.sv | 59 +++++
 rtl/fft_sdf_cmul.sv | 32 +++
 rtl/fft_sdf_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT stages: twiddle tables (Q1.15, largest
// supported FFT size), clog2, and the rounding and narrowing helpers.
package fft_pkg;

    localparam int MAX_N      = 16;
    localparam int TW_ENTRIES = MAX_N / 2;
    localparam int TW_IDX_W   = 3;

    // W^k = cos(2*pi*k/MAX_N) - j*sin(2*pi*k/MAX_N); the imaginary table holds -sin.
    localparam logic signed [15:0] TW_COS [TW_ENTRIES] = '{
        16'sd32767, 16'sd30274, 16'sd23170, 16'sd12540,
        16'sd0, -16'sd12540, -16'sd23170, -16'sd30274
    };
    localparam logic signed [15:0] TW_NSIN [TW_ENTRIES] = '{
        16'sd0, -16'sd12540, -16'sd23170, -16'sd30274,
        -16'sd32767, -16'sd30274, -16'sd23170, -16'sd12540
    };

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((32'sd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic signed [15:0] tw_re(input int k);
        return TW_COS[k[TW_IDX_W-1:0]];
    endfunction

    function automatic logic signed [15:0] tw_im(input int k);
        return TW_NSIN[k[TW_IDX_W-1:0]];
    endfunction

    // Divide by two, rounding half up.
    function automatic logic signed [63:0] round_half(input logic signed [63:0] v);
        return (v + 64'sd1) >>> 1;
    endfunction

    // Narrow to w bits: clip flags any lost significant bit; with sat set the
    // value is clamped, otherwise the caller's truncation wraps it.
    function automatic logic signed [63:0] narrow(input logic signed [63:0] v, input int w,
                                                  input logic sat, output logic clip);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi   = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo   = -(64'sd1 <<< (w - 1));
        clip = (v > hi) || (v < lo);
        if (sat && (v > hi)) begin
            return hi;
        end else if (sat && (v < lo)) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/fft_sdf_cmul.sv
// Combinational complex multiply with round-half-up back to the data scale
// (twiddle is Q1.(TW-1)); output carries two guard bits above AW.
module fft_sdf_cmul #(
    parameter int AW = 17,
    parameter int TW = 16
) (
    input  logic signed [AW-1:0] a_r,
    input  logic signed [AW-1:0] a_i,
    input  logic signed [TW-1:0] w_r,
    input  logic signed [TW-1:0] w_i,
    output logic signed [AW+1:0] p_r,
    output logic signed [AW+1:0] p_i
);
    localparam int PW = AW + TW;
    localparam logic signed [PW:0] RND = {{PW{1'b0}}, 1'b1} << (TW - 2);

    logic signed [PW-1:0] rr, ii, ri, ir;
    logic signed [PW:0]   acc_r, acc_i;

    // Four partial products, combine, round, rescale.
    always_comb begin
        rr    = PW'(a_r) * PW'(w_r);
        ii    = PW'(a_i) * PW'(w_i);
        ri    = PW'(a_r) * PW'(w_i);
        ir    = PW'(a_i) * PW'(w_r);
        acc_r = (PW+1)'(rr) - (PW+1)'(ii) + RND;
        acc_i = (PW+1)'(ri) + (PW+1)'(ir) + RND;
        p_r   = (AW+2)'(acc_r >>> (TW - 1));
        p_i   = (AW+2)'(acc_i >>> (TW - 1));
    end

endmodule

// File: rtl/fft_sdf_stage.sv
// Radix-2 DIF single-path delay-feedback FFT stage, one sample per clock.
// Define FFT_SDF_SAT_EN to saturate instead of wrap when narrowing.
module fft_sdf_stage
    import fft_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int TW_WIDTH = 16,
    parameter int N        = 8,
    parameter int STAGE    = 0,
    parameter int SCALE    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_sop,
    input  logic signed [WIDTH-1:0] in_r,
    input  logic signed [WIDTH-1:0] in_i,
    output logic                    out_valid,
    output logic                    out_sop,
    output logic signed [WIDTH-1:0] out_r,
    output logic signed [WIDTH-1:0] out_i,
    output logic                    ovf
);
    localparam int D       = N >> (STAGE + 1);
    localparam int CW      = (clog2(2 * D) < 1) ? 1 : clog2(2 * D);
    localparam int TW_STEP = MAX_N / N;
    localparam int TW_SHL  = (TW_WIDTH > 16) ? (TW_WIDTH - 16) : 0;
    localparam int TW_SHR  = (TW_WIDTH < 16) ? (16 - TW_WIDTH) : 0;
`ifdef FFT_SDF_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic [CW-1:0]           cnt_q, cnt_d, prime_q, prime_d, cnt_cur;
    logic                    sop_blk_q, sop_blk_d;
    logic                    out_valid_q, out_valid_d, out_sop_q, out_sop_d, ovf_q, ovf_d;
    logic signed [WIDTH-1:0] out_r_q, out_r_d, out_i_q, out_i_d;
    logic signed [WIDTH-1:0] buf_r_q [D];
    logic signed [WIDTH-1:0] buf_r_d [D];
    logic signed [WIDTH-1:0] buf_i_q [D];
    logic signed [WIDTH-1:0] buf_i_d [D];

    logic                    bfly;
    int                      kidx;
    logic signed [WIDTH:0]   sum_raw_r, sum_raw_i, dif_raw_r, dif_raw_i;
    logic signed [WIDTH:0]   sum_r, sum_i, dif_r, dif_i;
    logic signed [TW_WIDTH-1:0] w_r, w_i;
    logic signed [WIDTH+2:0] prod_r, prod_i;
    logic signed [63:0]      a_r64, a_i64, b_r64, b_i64;
    logic                    clip_ar, clip_ai, clip_br, clip_bi;

    fft_sdf_cmul #(.AW(WIDTH + 1), .TW(TW_WIDTH)) u_cmul (
        .a_r (dif_r),
        .a_i (dif_i),
        .w_r (w_r),
        .w_i (w_i),
        .p_r (prod_r),
        .p_i (prod_i)
    );

    // Butterfly datapath: phase, twiddle selection, sum and difference.
    always_comb begin
        cnt_cur   = (in_valid && in_sop) ? '0 : cnt_q;
        bfly      = (cnt_cur >= CW'(D));
        kidx      = bfly ? (((int'(cnt_cur) - D) << STAGE) * TW_STEP) : 0;
        w_r       = TW_WIDTH'((64'(tw_re(kidx)) <<< TW_SHL) >>> TW_SHR);
        w_i       = TW_WIDTH'((64'(tw_im(kidx)) <<< TW_SHL) >>> TW_SHR);
        sum_raw_r = (WIDTH+1)'(buf_r_q[D-1]) + (WIDTH+1)'(in_r);
        sum_raw_i = (WIDTH+1)'(buf_i_q[D-1]) + (WIDTH+1)'(in_i);
        dif_raw_r = (WIDTH+1)'(buf_r_q[D-1]) - (WIDTH+1)'(in_r);
        dif_raw_i = (WIDTH+1)'(buf_i_q[D-1]) - (WIDTH+1)'(in_i);
        sum_r = (SCALE != 0) ? (WIDTH+1)'(round_half(64'(sum_raw_r))) : sum_raw_r;
        sum_i = (SCALE != 0) ? (WIDTH+1)'(round_half(64'(sum_raw_i))) : sum_raw_i;
        dif_r = (SCALE != 0) ? (WIDTH+1)'(round_half(64'(dif_raw_r))) : dif_raw_r;
        dif_i = (SCALE != 0) ? (WIDTH+1)'(round_half(64'(dif_raw_i))) : dif_raw_i;
    end

    // Next-state: counters, delay line, registered output and sticky overflow.
    always_comb begin
        cnt_d       = cnt_q;
        prime_d     = prime_q;
        sop_blk_d   = sop_blk_q;
        out_valid_d = 1'b0;
        out_sop_d   = 1'b0;
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;
        ovf_d       = ovf_q;
        buf_r_d     = buf_r_q;
        buf_i_d     = buf_i_q;
        a_r64 = narrow(64'(sum_r), WIDTH, SAT, clip_ar);
        a_i64 = narrow(64'(sum_i), WIDTH, SAT, clip_ai);
        b_r64 = narrow(64'(prod_r), WIDTH, SAT, clip_br);
        b_i64 = narrow(64'(prod_i), WIDTH, SAT, clip_bi);
        if (in_valid) begin
            cnt_d       = cnt_cur + CW'(1);
            prime_d     = (prime_q == CW'(D)) ? prime_q : prime_q + CW'(1);
            sop_blk_d   = (cnt_cur == '0) ? in_sop : sop_blk_q;
            out_valid_d = (prime_q == CW'(D));
            out_sop_d   = (prime_q == CW'(D)) && (cnt_cur == CW'(D)) && sop_blk_q;
            for (int i = 1; i < D; i++) begin
                buf_r_d[i] = buf_r_q[i-1];
                buf_i_d[i] = buf_i_q[i-1];
            end
            if (bfly) begin
                out_r_d    = WIDTH'(a_r64);
                out_i_d    = WIDTH'(a_i64);
                buf_r_d[0] = WIDTH'(b_r64);
                buf_i_d[0] = WIDTH'(b_i64);
                ovf_d      = ovf_q | clip_ar | clip_ai | clip_br | clip_bi;
            end else begin
                // Drain the previous block's twiddled differences while filling.
                out_r_d    = buf_r_q[D-1];
                out_i_d    = buf_i_q[D-1];
                buf_r_d[0] = in_r;
                buf_i_d[0] = in_i;
            end
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            prime_q     <= '0;
            sop_blk_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < D; i++) begin
                buf_r_q[i] <= '0;
                buf_i_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            prime_q     <= prime_d;
            sop_blk_q   <= sop_blk_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
            ovf_q       <= ovf_d;
            buf_r_q     <= buf_r_d;
            buf_i_q     <= buf_i_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_r     = out_r_q;
    assign out_i     = out_i_q;
    assign ovf       = ovf_q;

endmodule
